bt_pipe_out_source: RTL

BT_PIPE_OUT_SOURCE -- requirements
Module: bt_pipe_out_source

---
 rtl/bt_pipe_pkg.sv | 13 +
 rtl/bt_fifo_sync.sv | 69 ++++++
 rtl/bt_pipe_out_source.sv | 100 ++++++++++
 3 files changed

// File: rtl/bt_pipe_pkg.sv
// Shared definitions for the block-throttled pipe-out source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bt_pipe_pkg;

   localparam int unsigned WORD_W = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BLOCK = 1'b1
   } bt_state_e;

endpackage : bt_pipe_pkg

// File: rtl/bt_fifo_sync.sv
// Circular word buffer with wrapping pointers and a registered read port.
// Latency: a pop in cycle N presents its word in cycle N+1; level updates one cycle after a push/pop.
// Backpressure: pushes while full are ignored; pops while empty leave pointers alone and return zero.
module bt_fifo_sync
   import bt_pipe_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [WORD_W-1:0]     wr_dat_i,
   input  logic                  rd_en_i,
   output logic [WORD_W-1:0]     rd_dat_o,
   output logic                  full_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic [DEPTH_LOG2:0]   level_nxt_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned LW    = DEPTH_LOG2 + 1;

   logic [WORD_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q,  level_d;
   logic [WORD_W-1:0]     rd_dat_q;
   logic                  full, empty, do_wr, do_rd;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign do_wr = wr_en_i & ~full;
   assign do_rd = rd_en_i & ~empty;

   // Next pointer and occupancy values; pointers wrap naturally at the depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(do_wr) - LW'(do_rd);
   end

   // Pointer, occupancy and read-data registers; an empty pop returns zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rd_dat_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         if (rd_en_i) rd_dat_q <= empty ? '0 : mem_q[rd_ptr_q];
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (!rst_i && do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
   end

   assign rd_dat_o    = rd_dat_q;
   assign full_o      = full;
   assign level_o     = level_q;
   assign level_nxt_o = rst_i ? '0 : level_d;

endmodule : bt_fifo_sync

// File: rtl/bt_pipe_out_source.sv
// User-side word buffer feeding a block-throttled pipe-out endpoint, with block sequencing and sticky error flags.
// Latency: ep_datain one cycle after ep_read; ep_ready registered from post-update level and block progress.
// Backpressure: full drops writes (overflow_err); ep_ready only asserts when a whole unclaimed block is buffered.
module bt_pipe_out_source
   import bt_pipe_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS = 256,
   parameter int unsigned DEPTH_LOG2  = 10
) (
   input  logic                  ti_clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WORD_W-1:0]     wr_data,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   input  logic                  ep_read,
   input  logic                  ep_blockstrobe,
   output logic [WORD_W-1:0]     ep_datain,
   output logic                  ep_ready,
   output logic                  overflow_err,
   output logic                  underflow_err,
   output logic                  protocol_err
);

   localparam int unsigned CW = DEPTH_LOG2 + 1;
   localparam int unsigned LW = DEPTH_LOG2 + 2;

   bt_state_e          state_q, state_d;
   logic [CW-1:0]      wcnt_q, wcnt_d;
   logic [CW-1:0]      owed_d;
   logic [DEPTH_LOG2:0] level_nxt;
   logic               ready_q, ready_d;
   logic               ovf_q, unf_q, proto_q;
   logic               proto_set;

   bt_fifo_sync #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk_i       (ti_clk),
      .rst_i       (reset),
      .wr_en_i     (wr_en),
      .wr_dat_i    (wr_data),
      .rd_en_i     (ep_read),
      .rd_dat_o    (ep_datain),
      .full_o      (full),
      .level_o     (level),
      .level_nxt_o (level_nxt)
   );

   // Block sequencing: accept a strobe only when idle with a block ready; count reads inside a block.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      proto_set = 1'b0;
      if (ep_blockstrobe) begin
         if (state_q == ST_IDLE && ready_q) begin
            state_d = ST_BLOCK;
            wcnt_d  = '0;
         end else begin
            proto_set = 1'b1;
         end
      end
      if (ep_read) begin
         if (state_q == ST_BLOCK) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q + 1'b1 == CW'(BLOCK_WORDS)) state_d = ST_IDLE;
         end else begin
            proto_set = 1'b1;
         end
      end
      owed_d  = (state_d == ST_BLOCK) ? CW'(BLOCK_WORDS) - wcnt_d : '0;
      // Compare as level >= owed + BLOCK_WORDS so an empty-buffer read mid-block cannot wrap negative.
      ready_d = ({1'b0, level_nxt} >= ({1'b0, owed_d} + LW'(BLOCK_WORDS)));
   end

   // State, counter, readiness and sticky error registers.
   always_ff @(posedge ti_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ready_q <= ready_d;
         if (wr_en && full)            ovf_q   <= 1'b1;
         if (ep_read && level == '0)   unf_q   <= 1'b1;
         if (proto_set)                proto_q <= 1'b1;
      end
   end

   assign ep_ready      = ready_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;
   assign protocol_err  = proto_q;

endmodule : bt_pipe_out_source
